// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the set-associative
// instruction cache and its replacement logic.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

    function automatic int byte_off_w(input int word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int word_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int word_w,
                                 input int sets, input int words_per_line);
        return addr_w - byte_off_w(word_w) - word_off_w(words_per_line) - index_w(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int plru_w(input int ways);
        return (ways == 4) ? 3 : 1;
    endfunction

endpackage

// File: rtl/icache_plru.sv
// Combinational victim selection and pseudo-LRU update for one cache set.
// Each PLRU bit points toward the side that should be evicted next.
module icache_plru
    import icache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int WAY_W  = 1,
    parameter int PLRU_W = 1
) (
    input  logic [PLRU_W-1:0] plru_bits,
    input  logic [WAYS-1:0]   valid,
    input  logic [WAY_W-1:0]  access_way,
    output logic [WAY_W-1:0]  victim,
    output logic [PLRU_W-1:0] next_bits
);

    logic [WAY_W-1:0] plru_victim;

    generate
        if (WAYS == 1) begin : g_one
            assign plru_victim = '0;
            assign next_bits   = plru_bits;
        end else if (WAYS == 2) begin : g_two
            assign plru_victim = plru_bits[0];
            assign next_bits   = ~access_way;
        end else begin : g_four
            // bit0 picks the half, bit1/bit2 pick within the left/right half
            assign plru_victim = plru_bits[0] ? {1'b1, plru_bits[2]} : {1'b0, plru_bits[1]};
            always_comb begin
                next_bits    = plru_bits;
                next_bits[0] = ~access_way[1];
                if (access_way[1])
                    next_bits[2] = ~access_way[0];
                else
                    next_bits[1] = ~access_way[0];
            end
        end
    endgenerate

    // An empty way always wins over the PLRU choice, lowest index first.
    always_comb begin
        victim = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w])
                victim = WAY_W'(w);
        end
    end

endmodule

// File: rtl/icache_assoc_fill.sv
// N-way set-associative instruction cache with an in-order line-fill
// controller and whole-cache flush; hits are served combinationally.
module icache_assoc_fill
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int WORD_W         = 16,
    parameter int WAYS           = 2,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [WORD_W-1:0] fetch_data,
    output logic              fetch_stall,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [WORD_W-1:0] mem_data
);

    localparam int BOFF_W   = byte_off_w(WORD_W);
    localparam int WOFF_W   = word_off_w(WORDS_PER_LINE);
    localparam int IDX_W    = index_w(SETS);
    localparam int TAG_W    = tag_w(ADDR_W, WORD_W, SETS, WORDS_PER_LINE);
    localparam int WAY_W    = way_w(WAYS);
    localparam int PLRU_W   = plru_w(WAYS);
    localparam int LINE_LSB = BOFF_W + WOFF_W;
    localparam int TAG_AW   = $clog2(SETS * WAYS);
    localparam int DATA_AW  = $clog2(SETS * WAYS * WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << LINE_LSB) - 1);

    state_t              state;
    logic [WAYS-1:0]     valid_arr [SETS];
    logic [PLRU_W-1:0]   plru_arr  [SETS];
    logic [TAG_W-1:0]    tag_arr   [SETS*WAYS];
    logic [WORD_W-1:0]   data_arr  [SETS*WAYS*WORDS_PER_LINE];

    logic [IDX_W-1:0]    miss_idx;
    logic [TAG_W-1:0]    miss_tag;
    logic [WAY_W-1:0]    fill_way;
    logic [WOFF_W-1:0]   beat_cnt;
    logic                flush_pend;

    logic [WOFF_W-1:0]   f_woff;
    logic [IDX_W-1:0]    f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic                hit_any;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                start_fill;
    logic [IDX_W-1:0]    plru_set;
    logic [WAY_W-1:0]    plru_access;
    logic [WAY_W-1:0]    victim;
    logic [PLRU_W-1:0]   plru_next;

    function automatic logic [TAG_AW-1:0] tag_addr(input logic [IDX_W-1:0] idx,
                                                   input logic [WAY_W-1:0] way);
        return TAG_AW'(int'(idx) * WAYS + int'(way));
    endfunction

    function automatic logic [DATA_AW-1:0] data_addr(input logic [IDX_W-1:0]  idx,
                                                     input logic [WAY_W-1:0]  way,
                                                     input logic [WOFF_W-1:0] woff);
        return DATA_AW'((int'(idx) * WAYS + int'(way)) * WORDS_PER_LINE + int'(woff));
    endfunction

    assign f_woff = fetch_addr[BOFF_W +: WOFF_W];
    assign f_idx  = fetch_addr[LINE_LSB +: IDX_W];
    assign f_tag  = fetch_addr[ADDR_W-1 -: TAG_W];

    always_comb begin
        hit_any    = 1'b0;
        hit_way    = '0;
        fetch_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[f_idx][w] && tag_arr[tag_addr(f_idx, WAY_W'(w))] == f_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit = fetch_req && hit_any && (state == IDLE);
        if (hit)
            fetch_data = data_arr[data_addr(f_idx, hit_way, f_woff)];
    end

    assign fetch_stall = fetch_req && !hit;
    assign start_fill  = (state == IDLE) && fetch_req && !hit && !flush;

    // Lookups use the fetch set; the commit cycle uses the captured miss set.
    assign plru_set    = (state == IDLE) ? f_idx   : miss_idx;
    assign plru_access = (state == IDLE) ? hit_way : fill_way;

    icache_plru #(
        .WAYS   (WAYS),
        .WAY_W  (WAY_W),
        .PLRU_W (PLRU_W)
    ) u_plru (
        .plru_bits  (plru_arr[plru_set]),
        .valid      (valid_arr[plru_set]),
        .access_way (plru_access),
        .victim     (victim),
        .next_bits  (plru_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (hit)
                        plru_arr[f_idx] <= plru_next;
                    if (flush) begin
                        for (int s = 0; s < SETS; s++)
                            valid_arr[s] <= '0;
                    end else if (start_fill) begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_addr & ~OFF_MASK;
                        beat_cnt <= '0;
                    end
                end
                FILL: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    if (mem_data_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == WOFF_W'(WORDS_PER_LINE - 1)) begin
                            mem_req <= 1'b0;
                            state   <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    plru_arr[miss_idx] <= plru_next;
                    // A flush seen during the fill also drops the line just filled.
                    if (flush_pend || flush) begin
                        for (int s = 0; s < SETS; s++)
                            valid_arr[s] <= '0;
                    end else begin
                        valid_arr[miss_idx][fill_way] <= 1'b1;
                    end
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (start_fill) begin
            miss_idx <= f_idx;
            miss_tag <= f_tag;
            fill_way <= victim;
        end
        if (state == FILL && mem_data_valid)
            data_arr[data_addr(miss_idx, fill_way, beat_cnt)] <= mem_data;
        if (state == COMMIT)
            tag_arr[tag_addr(miss_idx, fill_way)] <= miss_tag;
    end

endmodule

// File: tb/tb_icache_assoc_fill.sv
// Self-checking bench for icache_assoc_fill against a resident-line model with
// true LRU per set (identical to PLRU at two ways).
module tb_icache_assoc_fill;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;
    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int WPL    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic [15:0] fetch_data;
    logic        fetch_stall;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data = '0;

    int checks = 0;
    int errors = 0;

    icache_assoc_fill #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WAYS(WAYS), .SETS(SETS), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_stall(fetch_stall), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data_valid(mem_data_valid),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_vld   [SETS][WAYS];
    logic [15:0] m_tag   [SETS][WAYS];
    int          m_stamp [SETS][WAYS];
    logic [15:0] m_data  [SETS][WAYS][WPL];
    int          m_time;
    logic [15:0] line_buf [WPL];

    function automatic int set_of(input logic [15:0] a);
        return int'((a >> 4) & 16'h003F);
    endfunction
    function automatic logic [15:0] tag_of(input logic [15:0] a);
        return a >> 10;
    endfunction
    function automatic int word_of(input logic [15:0] a);
        return int'((a >> 1) & 16'h0007);
    endfunction

    task automatic m_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                m_vld[s][w] = 1'b0;
    endtask

    task automatic m_reset();
        m_flush();
        m_time = 0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                m_stamp[s][w] = 0;
    endtask

    task automatic m_expect(input logic [15:0] a, output bit h, output logic [15:0] d);
        int s;
        s = set_of(a);
        h = 1'b0;
        d = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_vld[s][w] && m_tag[s][w] == tag_of(a)) begin
                h = 1'b1;
                d = m_data[s][w][word_of(a)];
            end
    endtask

    task automatic m_touch(input logic [15:0] a);
        int s;
        s = set_of(a);
        for (int w = 0; w < WAYS; w++)
            if (m_vld[s][w] && m_tag[s][w] == tag_of(a)) begin
                m_time++;
                m_stamp[s][w] = m_time;
            end
    endtask

    task automatic m_fill(input logic [15:0] a);
        int s;
        int v;
        s = set_of(a);
        v = -1;
        for (int w = 0; w < WAYS; w++)
            if (!m_vld[s][w] && v < 0) v = w;
        if (v < 0) begin
            v = 0;
            for (int w = 1; w < WAYS; w++)
                if (m_stamp[s][w] < m_stamp[s][v]) v = w;
        end
        m_vld[s][v] = 1'b1;
        m_tag[s][v] = tag_of(a);
        for (int i = 0; i < WPL; i++) m_data[s][v][i] = line_buf[i];
        m_time++;
        m_stamp[s][v] = m_time;
    endtask

    // ---------------- stimulus helpers (observe only) ----------------
    task automatic look(input logic [15:0] a, input bit hold,
                        output logic st, output logic [15:0] d);
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = a;
        flush = 1'b0;
        mem_data_valid = 1'b0;
        #1;
        st = fetch_stall;
        d = fetch_data;
        if (!hold) begin
            #1;
            fetch_req = 1'b0;
        end
    endtask

    task automatic run_fill(input logic [15:0] a, input int gap_beat, input int gap_len,
                            input int flush_beat, input bit wander,
                            output logic miss_stall, output int req_wait,
                            output logic [15:0] got_addr, output logic addr_stable,
                            output logic fill_stall, output logic req_after,
                            output logic commit_stall);
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = a;
        flush = 1'b0;
        mem_data_valid = 1'b0;
        #1;
        miss_stall = fetch_stall;
        req_wait = 0;
        @(negedge clk);
        while (!mem_req && req_wait < 4) begin
            @(negedge clk);
            req_wait++;
        end
        got_addr = mem_addr;
        addr_stable = 1'b1;
        fill_stall = 1'b1;
        for (int b = 0; b < WPL; b++) begin
            if (b == gap_beat)
                for (int g = 0; g < gap_len; g++) begin
                    mem_data_valid = 1'b0;
                    flush = 1'b0;
                    #1;
                    if (mem_addr !== got_addr || mem_req !== 1'b1) addr_stable = 1'b0;
                    @(negedge clk);
                end
            mem_data_valid = 1'b1;
            mem_data = line_buf[b];
            flush = (b == flush_beat);
            if (wander) fetch_addr = 16'($urandom);
            #1;
            if (mem_addr !== got_addr || mem_req !== 1'b1) addr_stable = 1'b0;
            if (fetch_stall !== 1'b1) fill_stall = 1'b0;
            @(negedge clk);
        end
        // Stray beat during COMMIT must be ignored.
        mem_data_valid = 1'b1;
        mem_data = 16'($urandom);
        flush = 1'b0;
        fetch_addr = a;
        #1;
        req_after = mem_req;
        commit_stall = fetch_stall;
    endtask

    // ---------------- tests ----------------
    logic        ms, as, fs, ra, cs, st;
    int          rw;
    logic [15:0] ga, d, ed;
    bit          eh;

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 16'h1234;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_req1: got %b want 1", fetch_stall); end
        checks++; if (fetch_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", fetch_data); end
        fetch_req = 1'b0;
        #1;
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_req0: got %b want 0", fetch_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_cold_miss();
        for (int i = 0; i < WPL; i++) line_buf[i] = 16'(i);
        run_fill(16'h1234, -1, 0, -1, 1'b0, ms, rw, ga, as, fs, ra, cs);
        checks++; if (ms !== 1'b1) begin errors++; $display("FAIL cold_miss_stall: got %b want 1", ms); end
        checks++; if (rw !== 0) begin errors++; $display("FAIL cold_req_latency: got %0d want 0", rw); end
        checks++; if (ga !== 16'h1230) begin errors++; $display("FAIL cold_mem_addr: got %h want 1230", ga); end
        checks++; if (as !== 1'b1) begin errors++; $display("FAIL cold_addr_stable: got %b want 1", as); end
        checks++; if (fs !== 1'b1) begin errors++; $display("FAIL cold_fill_stall: got %b want 1", fs); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL cold_req_drop: got %b want 0", ra); end
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL cold_commit_stall: got %b want 1", cs); end
        m_fill(16'h1234);
        m_expect(16'h1234, eh, ed);
        look(16'h1234, 1'b1, st, d);
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL cold_hit_stall: got %b want 0", st); end
        checks++; if (d !== ed) begin errors++; $display("FAIL cold_hit_data: got %h want %h", d, ed); end
        m_touch(16'h1234);
    endtask

    task automatic test_same_line();
        m_expect(16'h123E, eh, ed);
        look(16'h123E, 1'b1, st, d);
        checks++; if (st !== 1'b0 || d !== ed) begin errors++; $display("FAIL line_word7: got %b/%h want 0/%h", st, d, ed); end
        m_touch(16'h123E);
        m_expect(16'h1230, eh, ed);
        look(16'h1230, 1'b1, st, d);
        checks++; if (st !== 1'b0 || d !== ed) begin errors++; $display("FAIL line_word0: got %b/%h want 0/%h", st, d, ed); end
        m_touch(16'h1230);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL line_no_req: got %b want 0", mem_req); end
    endtask

    task automatic test_conflict_lru();
        for (int i = 0; i < WPL; i++) line_buf[i] = 16'($urandom);
        run_fill(16'h5634, -1, 0, -1, 1'b0, ms, rw, ga, as, fs, ra, cs);
        checks++; if (ms !== 1'b1 || ga !== 16'h5630) begin errors++; $display("FAIL lru_fill2: got %b/%h want 1/5630", ms, ga); end
        m_fill(16'h5634);
        m_expect(16'h1234, eh, ed);
        look(16'h1234, 1'b1, st, d);
        checks++; if (st !== !eh || d !== ed) begin errors++; $display("FAIL lru_touch: got %b/%h want %b/%h", st, d, !eh, ed); end
        m_touch(16'h1234);
        for (int i = 0; i < WPL; i++) line_buf[i] = 16'($urandom);
        run_fill(16'h9A34, -1, 0, -1, 1'b0, ms, rw, ga, as, fs, ra, cs);
        checks++; if (ms !== 1'b1 || ga !== 16'h9A30) begin errors++; $display("FAIL lru_fill3: got %b/%h want 1/9a30", ms, ga); end
        m_fill(16'h9A34);
        m_expect(16'h1234, eh, ed);
        look(16'h1234, 1'b0, st, d);
        checks++; if (st !== !eh || d !== ed) begin errors++; $display("FAIL lru_keep: got %b/%h want %b/%h", st, d, !eh, ed); end
        m_expect(16'h5634, eh, ed);
        look(16'h5634, 1'b0, st, d);
        checks++; if (st !== !eh) begin errors++; $display("FAIL lru_evicted: got stall %b want %b", st, !eh); end
        m_expect(16'h9A3C, eh, ed);
        look(16'h9A3C, 1'b1, st, d);
        checks++; if (st !== !eh || d !== ed) begin errors++; $display("FAIL lru_new: got %b/%h want %b/%h", st, d, !eh, ed); end
        m_touch(16'h9A3C);
    endtask

    task automatic test_beat_gaps();
        for (int i = 0; i < WPL; i++) line_buf[i] = 16'($urandom);
        run_fill(16'h3C06, 4, 3, -1, 1'b1, ms, rw, ga, as, fs, ra, cs);
        checks++; if (ga !== 16'h3C00 || as !== 1'b1) begin errors++; $display("FAIL gap_addr: got %h/%b want 3c00/1", ga, as); end
        checks++; if (ra !== 1'b0 || fs !== 1'b1) begin errors++; $display("FAIL gap_req_stall: got %b/%b want 0/1", ra, fs); end
        m_fill(16'h3C06);
        for (int w = 0; w < WPL; w++) begin
            m_expect(16'h3C00 | 16'(w << 1), eh, ed);
            look(16'h3C00 | 16'(w << 1), 1'b1, st, d);
            checks++; if (st !== !eh || d !== ed) begin errors++; $display("FAIL gap_word%0d: got %b/%h want %b/%h", w, st, d, !eh, ed); end
            m_touch(16'h3C00 | 16'(w << 1));
        end
    endtask

    task automatic test_flush_idle();
        m_expect(16'h1234, eh, ed);
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = 16'h1234;
        flush = 1'b1;
        mem_data_valid = 1'b0;
        #1;
        checks++; if (fetch_stall !== !eh || fetch_data !== ed) begin errors++; $display("FAIL flush_hit_same_cycle: got %b/%h want %b/%h", fetch_stall, fetch_data, !eh, ed); end
        @(negedge clk);
        flush = 1'b0;
        fetch_req = 1'b0;
        m_flush();
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_idle_no_fill: got %b want 0", mem_req); end
        m_expect(16'h1234, eh, ed);
        look(16'h1234, 1'b0, st, d);
        checks++; if (st !== !eh) begin errors++; $display("FAIL flush_idle_miss: got stall %b want %b", st, !eh); end
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = 16'h5634;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch_req = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_miss_no_fill: got %b want 0", mem_req); end
    endtask

    task automatic test_flush_mid_fill();
        logic [15:0] probe [5];
        probe = '{16'h1234, 16'h5634, 16'h9A34, 16'h2468, 16'h3C00};
        for (int i = 0; i < WPL; i++) line_buf[i] = 16'($urandom);
        run_fill(16'h2468, -1, 0, 2, 1'b0, ms, rw, ga, as, fs, ra, cs);
        checks++; if (ms !== 1'b1 || as !== 1'b1) begin errors++; $display("FAIL midflush_fill: got %b/%b want 1/1", ms, as); end
        checks++; if (ra !== 1'b0 || cs !== 1'b1) begin errors++; $display("FAIL midflush_commit: got %b/%b want 0/1", ra, cs); end
        m_fill(16'h2468);
        m_flush();
        for (int i = 0; i < 5; i++) begin
            m_expect(probe[i], eh, ed);
            look(probe[i], 1'b0, st, d);
            checks++; if (st !== !eh) begin errors++; $display("FAIL midflush_probe_%h: got stall %b want %b", probe[i], st, !eh); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = 16'h1234;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL rstfill_req: waited %0d want 0", n); end
        for (int b = 0; b < 5; b++) begin
            mem_data_valid = 1'b1;
            mem_data = 16'hDEA0 ^ 16'(b);
            @(negedge clk);
        end
        mem_data_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL rstfill_async: got %b/%h want 0/0000", mem_req, mem_addr); end
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL rstfill_stall: got %b want 1", fetch_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        fetch_req = 1'b0;
        m_reset();
        for (int i = 0; i < WPL; i++) line_buf[i] = 16'($urandom);
        run_fill(16'h1234, -1, 0, -1, 1'b0, ms, rw, ga, as, fs, ra, cs);
        checks++; if (ms !== 1'b1 || rw !== 0 || ga !== 16'h1230) begin errors++; $display("FAIL rstfill_refill: got %b/%0d/%h want 1/0/1230", ms, rw, ga); end
        m_fill(16'h1234);
        for (int w = 0; w < WPL; w++) begin
            m_expect(16'h1230 | 16'(w << 1), eh, ed);
            look(16'h1230 | 16'(w << 1), 1'b1, st, d);
            checks++; if (st !== !eh || d !== ed) begin errors++; $display("FAIL rstfill_word%0d: got %b/%h want %b/%h", w, st, d, !eh, ed); end
            m_touch(16'h1230 | 16'(w << 1));
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [4];
        logic [15:0] a;
        int s;
        pool = '{16'h01, 16'h15, 16'h2A, 16'h3F};
        for (int it = 0; it < 40; it++) begin
            s = ($urandom_range(0, 1) != 0) ? 5 : 9;
            a = 16'(pool[$urandom_range(0, 3)] << 10) | 16'(s << 4) | 16'($urandom_range(0, 7) << 1);
            m_expect(a, eh, ed);
            if (eh) begin
                look(a, 1'b1, st, d);
                checks++; if (st !== 1'b0 || d !== ed) begin errors++; $display("FAIL rand_hit_%h: got %b/%h want 0/%h", a, st, d, ed); end
                m_touch(a);
            end else begin
                for (int i = 0; i < WPL; i++) line_buf[i] = 16'($urandom);
                run_fill(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), -1, 1'b1,
                         ms, rw, ga, as, fs, ra, cs);
                checks++; if (ms !== 1'b1 || rw !== 0 || ga !== (a & 16'hFFF0) || ra !== 1'b0)
                    begin errors++; $display("FAIL rand_fill_%h: got %b/%0d/%h/%b want 1/0/%h/0", a, ms, rw, ga, ra, a & 16'hFFF0); end
                m_fill(a);
                m_expect(a, eh, ed);
                look(a, 1'b1, st, d);
                checks++; if (st !== !eh || d !== ed) begin errors++; $display("FAIL rand_after_%h: got %b/%h want %b/%h", a, st, d, !eh, ed); end
                m_touch(a);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_same_line();
        test_conflict_lru();
        test_beat_gaps();
        test_flush_idle();
        test_flush_mid_fill();
        test_reset_mid_fill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
